systolic_data_deskew_col: RTL and testbench
===========================================

// Module: systolic_data_deskew_col
// PURPOSE
//   Receive-side counterpart of the column data-setup skewer. Accepts the
//   diagonally skewed wavefront stream leaving the systolic array (one beat
//   per cycle, lane i delayed i beats) and reassembles the original
//   MATRIX_SIZE x MATRIX_SIZE matrix. Presents it as one block with a
//   valid/ready handshake to the result writeback stage.
// PARAMETERS
//   DATA_BITS    8    width of one matrix element
//   MATRIX_SIZE  4    N; matrix is N x N, stream has N lanes
//   OUTPUT_SIZE  2*MATRIX_SIZE-1   beats per skewed block (derived, do not override)
// PORTS
//   clock      in   1               single clock, rising edge
//   reset      in   1               asynchronous, active-high
//   in_valid   in   1               beat on data_in is valid
//   in_ready   out  1               block can accept a beat
//   data_in    in   N*DATA_BITS     lane i at [i*DATA_BITS +: DATA_BITS]
//   out_valid  out  1               reassembled matrix available
//   out_ready  in   1               consumer takes matrix
//   data_out   out  N*N*DATA_BITS   element [r][c] at [(r*N+c)*DATA_BITS +: DATA_BITS]
//   skew_err   out  1               sticky: nonzero data seen in a dead lane slot
// BEHAVIOUR
//   - Reset (async): state=FILL, beat counter k=0, matrix buffer all zero,
//     in_ready=1, out_valid=0, data_out=0, skew_err=0.
//   - States: FILL (in_ready=1, out_valid=0), DRAIN (in_ready=0, out_valid=1).
//   - FILL: a beat is accepted when in_valid && in_ready. For accepted beat k
//     (0..OUTPUT_SIZE-1), lane i is live iff i <= k <= i+N-1. A live lane
//     writes buf[k-i][i] <= lane i. A dead lane is not stored; if it is
//     nonzero, skew_err is set.
//   - Counter k increments per accepted beat and does not advance without
//     in_valid (bubbles allowed anywhere inside a block).
//   - After accepting beat k=OUTPUT_SIZE-1: next cycle state=DRAIN, k=0.
//     Latency: out_valid rises 1 cycle after the last beat is accepted.
//   - DRAIN: data_out = buf, held stable while out_valid && !out_ready.
//     in_valid is ignored (in_ready=0, no beat consumed).
//   - When out_valid && out_ready: next cycle state=FILL, in_ready=1.
//     buf is not cleared, because every live slot is rewritten by the
//     next block.
//   - data_out is driven from buf only in DRAIN; it is zero in FILL.
//   - skew_err clears only on reset.
//   - Reset mid-block drops the partial block: k=0, buf zero, FILL.
//   - Arithmetic: no data transform. k is $clog2(OUTPUT_SIZE) bits wide
//     and never wraps past OUTPUT_SIZE-1.
// TESTING  (N=4, DATA_BITS=8, so 7 beats)
//   1. Basic: skewed stream of M[r][c]=16*r+c, in_valid high 7 cycles, out_ready=1
//      -> out_valid for exactly 1 cycle, on the cycle after beat 6;
//      data_out[r][c]=16*r+c; skew_err=0.
//   2. Backpressure: same stream, out_ready=0 for 5 cycles
//      -> out_valid held 5 cycles; data_out stable; in_ready=0; in_valid
//      pulses ignored.
//   3. Bubbles: in_valid deasserted for 2 cycles after beats 1 and 4
//      -> same matrix as test 1; out_valid after 7th accepted beat.
//   4. Back-to-back: two blocks A=M, B=M+0x80, out_ready=1
//      -> A then B on data_out; in_ready low exactly 1 cycle between blocks.
//   5. Dead lane: lane 3 = 0xFF on beat 0 -> skew_err=1 and stays set;
//      matrix unaffected.
//   6. Reset mid-block: assert reset after beat 3, then send full block C
//      -> data_out = C only; no out_valid before C completes; skew_err=0.

Source files
------------

// File: rtl/systolic_data_deskew_col.sv
// Reassembles an N x N matrix from the diagonally skewed wavefront stream
// leaving a systolic array, then hands it on as one block via valid/ready.
module systolic_data_deskew_col #(
    parameter  int DATA_BITS   = 8,
    parameter  int MATRIX_SIZE = 4,
    localparam int OUTPUT_SIZE = 2 * MATRIX_SIZE - 1
) (
    input  logic                                       clock,
    input  logic                                       reset,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [MATRIX_SIZE*DATA_BITS-1:0]           data_in,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_BITS-1:0] data_out,
    output logic                                       skew_err
);

    localparam int K_BITS = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
    localparam logic [K_BITS-1:0] K_LAST  = K_BITS'(OUTPUT_SIZE - 1);
    localparam logic [K_BITS-1:0] ROW_MAX = K_BITS'(MATRIX_SIZE - 1);

    typedef enum logic {
        FILL,
        DRAIN
    } state_t;

    state_t                 state_reg, state_next;
    logic [K_BITS-1:0]      k_reg, k_next;
    logic [DATA_BITS-1:0]   mat_reg [MATRIX_SIZE][MATRIX_SIZE];
    logic                   skew_err_reg;
    logic [MATRIX_SIZE-1:0] dead_hit;
    logic                   beat_accept;

    assign beat_accept = in_valid && (state_reg == FILL);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= FILL;
            k_reg     <= '0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (k_reg == K_LAST) begin
                        k_next     = '0;
                        state_next = DRAIN;
                    end else begin
                        k_next = k_reg + 1'b1;
                    end
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    // Beat k carries element [r][c] on lane c exactly when r + c == k, so the
    // equality below doubles as the live-slot test for the write path.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < MATRIX_SIZE; r++) begin
                for (int c = 0; c < MATRIX_SIZE; c++) begin
                    mat_reg[r][c] <= '0;
                end
            end
        end else if (beat_accept) begin
            for (int r = 0; r < MATRIX_SIZE; r++) begin
                for (int c = 0; c < MATRIX_SIZE; c++) begin
                    if (k_reg == K_BITS'(r + c)) begin
                        mat_reg[r][c] <= data_in[c*DATA_BITS +: DATA_BITS];
                    end
                end
            end
        end
    end

    // Modular k - lane lands above ROW_MAX for both too-early and too-late
    // beats, because 2^K_BITS >= 2N-1 leaves no aliasing.
    generate
        for (genvar gi = 0; gi < MATRIX_SIZE; gi++) begin : g_lane
            localparam logic [K_BITS-1:0] LANE_LO = K_BITS'(gi);
            logic [K_BITS-1:0] row_off;
            assign row_off      = k_reg - LANE_LO;
            assign dead_hit[gi] = (row_off > ROW_MAX) &&
                                  (|data_in[gi*DATA_BITS +: DATA_BITS]);
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            skew_err_reg <= 1'b0;
        end else if (beat_accept && (|dead_hit)) begin
            skew_err_reg <= 1'b1;
        end
    end

    assign skew_err = skew_err_reg;

    generate
        for (genvar gi = 0; gi < MATRIX_SIZE; gi++) begin : g_row
            for (genvar gj = 0; gj < MATRIX_SIZE; gj++) begin : g_col
                assign data_out[(gi*MATRIX_SIZE+gj)*DATA_BITS +: DATA_BITS] =
                    (state_reg == DRAIN) ? mat_reg[gi][gj] : '0;
            end
        end
    endgenerate

endmodule

// File: tb/tb_systolic_data_deskew_col.sv
// Directed bench for the column deskewer: block vectors from a table plus a
// hand-written reset-mid-block sequence.
module tb_systolic_data_deskew_col;

    localparam int N  = 4;
    localparam int DB = 8;
    localparam int OS = 2 * N - 1;

    logic               clock = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [N*DB-1:0]    data_in;
    logic               out_valid;
    logic               out_ready;
    logic [N*N*DB-1:0]  data_out;
    logic               skew_err;

    int checks = 0;
    int errors = 0;

    systolic_data_deskew_col #(
        .DATA_BITS   (DB),
        .MATRIX_SIZE (N)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .skew_err  (skew_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        int    base;
        int    bubble_mask;
        int    hold;
        bit    dead;
        bit    exp_err;
        string name;
    } vec_t;

    vec_t vecs[7];

    function automatic vec_t mk(int base, int bubble_mask, int hold, bit dead,
                                bit exp_err, string name);
        vec_t v;
        v.base        = base;
        v.bubble_mask = bubble_mask;
        v.hold        = hold;
        v.dead        = dead;
        v.exp_err     = exp_err;
        v.name        = name;
        return v;
    endfunction

    function automatic logic [DB-1:0] elem(int base, int r, int c);
        return DB'(16 * r + c + base);
    endfunction

    function automatic logic [N*N*DB-1:0] exp_mat(int base);
        logic [N*N*DB-1:0] m;
        m = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                m[(r*N+c)*DB +: DB] = elem(base, r, c);
        return m;
    endfunction

    // Skewed beat k: lane i carries M[k-i][i] when live, else zero.
    function automatic logic [N*DB-1:0] beat(int base, int k, bit dead);
        logic [N*DB-1:0] b;
        b = '0;
        for (int i = 0; i < N; i++) begin
            if (k >= i && k <= i + N - 1)
                b[i*DB +: DB] = elem(base, k - i, i);
        end
        if (dead && k == 0)
            b[(N-1)*DB +: DB] = 8'hFF;
        return b;
    endfunction

    task automatic check(string name, logic [N*N*DB-1:0] act, logic [N*N*DB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_block(input vec_t v);
        bit                early;
        int                n;
        logic [N*N*DB-1:0] em;
        early     = 1'b0;
        em        = exp_mat(v.base);
        out_ready = (v.hold == 0);
        for (int k = 0; k < OS; k++) begin
            if (out_valid || !in_ready) early = 1'b1;
            in_valid = 1'b1;
            data_in  = beat(v.base, k, v.dead);
            @(posedge clock); #1;
            in_valid = 1'b0;
            data_in  = '0;
            if (v.bubble_mask[k]) begin
                repeat (2) begin
                    if (out_valid || !in_ready) early = 1'b1;
                    data_in = '1;
                    @(posedge clock); #1;
                end
                data_in = '0;
            end
        end
        check({v.name, " early_or_stall"}, early, 1'b0);
        n = (v.hold > 0) ? v.hold : 1;
        for (int h = 0; h < n; h++) begin
            check({v.name, " out_valid"}, out_valid, 1'b1);
            check({v.name, " data_out"}, data_out, em);
            check({v.name, " in_ready_drain"}, in_ready, 1'b0);
            out_ready = (h == n - 1);
            if (h != n - 1) begin
                in_valid = 1'b1;
                data_in  = {N{8'hAA}};
            end
            @(posedge clock); #1;
            in_valid = 1'b0;
            data_in  = '0;
        end
        check({v.name, " out_valid_drop"}, out_valid, 1'b0);
        check({v.name, " in_ready_back"}, in_ready, 1'b1);
        check({v.name, " data_out_fill"}, data_out, '0);
        check({v.name, " skew_err"}, skew_err, v.exp_err);
        $display("block %s base=%0h hold=%0d done", v.name, v.base, v.hold);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = mk(0,    0,        0, 1'b0, 1'b0, "basic");
        vecs[1] = mk(0,    0,        5, 1'b0, 1'b0, "backpressure");
        vecs[2] = mk(0,    'b10010,  0, 1'b0, 1'b0, "bubbles");
        vecs[3] = mk(0,    0,        0, 1'b0, 1'b0, "b2b_A");
        vecs[4] = mk(8'h80, 0,       0, 1'b0, 1'b0, "b2b_B");
        vecs[5] = mk(0,    0,        0, 1'b1, 1'b1, "dead_lane");
        vecs[6] = mk(8'h80, 0,       0, 1'b0, 1'b1, "sticky_err");

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        data_in   = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset in_ready", in_ready, 1'b1);
        check("reset out_valid", out_valid, 1'b0);
        check("reset data_out", data_out, '0);
        check("reset skew_err", skew_err, 1'b0);
        reset = 1'b0;

        for (int t = 0; t < 7; t++)
            run_block(vecs[t]);

        // Partial block, then reset: the fragment must vanish entirely.
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            data_in  = beat(8'h40, k, 1'b0);
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        data_in  = '0;
        reset    = 1'b1;
        #2;
        check("midreset out_valid", out_valid, 1'b0);
        check("midreset in_ready", in_ready, 1'b1);
        check("midreset skew_err", skew_err, 1'b0);
        check("midreset data_out", data_out, '0);
        @(posedge clock); #1;
        reset = 1'b0;
        run_block(mk(8'h20, 0, 0, 1'b0, 1'b0, "after_reset_C"));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
